// File: rtl/fp16_mac_pkg.sv
// Shared definitions for the fp16 multiplier front-end.
//   FP16_W   : width of an fp16 operand/result
//   FP16_ONE : encoding of +1.0
//   FP16_NAN : a NaN encoding used by callers for pass-through tests
//   state_t  : issue FSM states (IDLE=0, ISSUE=1, DONE=2)
package fp16_mac_pkg;

   localparam int unsigned FP16_W = 16;

   localparam logic [FP16_W-1:0] FP16_ONE = 16'h3C00;
   localparam logic [FP16_W-1:0] FP16_NAN = 16'h7C01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// Requester and result handshake bundle of fp16_mul_arbiter.
//   req0_*/req1_* : operand pair, valid and ready per requester
//   res_*         : result data, owner id and valid/ready handshake
// Modports: slave = arbiter side, master = requester/consumer side.
interface fp16_mul_arbiter_if;
   import fp16_mac_pkg::*;

   logic              req0_valid;
   logic              req1_valid;
   logic [FP16_W-1:0] req0_a;
   logic [FP16_W-1:0] req0_b;
   logic [FP16_W-1:0] req1_a;
   logic [FP16_W-1:0] req1_b;
   logic              req0_ready;
   logic              req1_ready;
   logic              res_valid;
   logic [FP16_W-1:0] res_data;
   logic              res_id;
   logic              res_ready;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res_ready,
      output req0_ready, req1_ready, res_valid, res_data, res_id
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res_ready,
      input  req0_ready, req1_ready, res_valid, res_data, res_id
   );

endinterface

// File: rtl/fp16_rr_arb2.sv
// Two-input grant logic with last-grant pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : a grant may be issued this cycle
//   req0, req1 : requests
//   gnt0, gnt1 : one-hot (or zero) combinational grants
// Parameter RR_EN: 1 = round-robin, 0 = fixed priority to requester 0.
module fp16_rr_arb2 #(
   parameter bit RR_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   // Index of the requester that wins a tie; resets to requester 0.
   logic pref;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (en) begin
         if (req0 && req1) begin
            if (pref) gnt1 = 1'b1;
            else      gnt0 = 1'b1;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   generate
      if (RR_EN) begin : g_rr
         // After granting requester 0 the tie goes to requester 1, and vice versa.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)            pref <= 1'b0;
            else if (gnt0 || gnt1) pref <= gnt0;
         end
      end else begin : g_fixed
         assign pref = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Arbitrates two requesters onto one external registered fp16 multiplier.
//   CLK, RESETn : clock, asynchronous active-low reset
//   bus         : requester/result handshakes (fp16_mul_arbiter_if.slave)
//   mul_a/mul_b : registered operands to the multiplier
//   mul_out     : multiplier product, valid one cycle after mul_a/mul_b
//   cnt0/cnt1   : per-requester completed-result counters, present only
//                 when FP16_MUL_ARBITER_PERF_EN is defined
// Parameters: RR_EN (1 round-robin, 0 fixed priority), CNT_W (counter width).
module fp16_mul_arbiter
   import fp16_mac_pkg::*;
#(
   parameter bit          RR_EN = 1'b1,
   parameter int unsigned CNT_W = 16
) (
   input  logic              CLK,
   input  logic              RESETn,
   fp16_mul_arbiter_if.slave bus,
   output logic [FP16_W-1:0] mul_a,
   output logic [FP16_W-1:0] mul_b,
   input  logic [FP16_W-1:0] mul_out
`ifdef FP16_MUL_ARBITER_PERF_EN
   ,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
`endif
);

   state_t state, state_nxt;
   logic   gnt0, gnt1, grant, grant_en, res_hs, id_q;

   assign res_hs = (state == DONE) && bus.res_ready;
   // Gated by RESETn so no ready is presented while reset is held.
   assign grant_en = RESETn && ((state == IDLE) || res_hs);
   assign grant    = gnt0 || gnt1;

   fp16_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
      .clk   (CLK),
      .rst_n (RESETn),
      .en    (grant_en),
      .req0  (bus.req0_valid),
      .req1  (bus.req1_valid),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant) state_nxt = ISSUE;
         ISSUE:   state_nxt = DONE;
         DONE:    if (bus.res_ready) state_nxt = grant ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= IDLE;
         mul_a <= '0;
         mul_b <= '0;
         id_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            mul_a <= gnt1 ? bus.req1_a : bus.req0_a;
            mul_b <= gnt1 ? bus.req1_b : bus.req0_b;
            id_q  <= gnt1;
         end
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.res_valid  = (state == DONE);
   assign bus.res_data   = mul_out;
   assign bus.res_id     = id_q;

`ifdef FP16_MUL_ARBITER_PERF_EN
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (res_hs) begin
         if (id_q) cnt1 <= cnt1 + 1'b1;
         else      cnt0 <= cnt0 + 1'b1;
      end
   end
`endif

endmodule
